fft_frame_sink: RTL

Receiving end of the FFT push/stall output stream. Accepts one 16-point complex frame from `fft_top` (`out_push_F`/`out_real_F`/`out_imag_F`, driving its `out_stall`) and stores it in a frame buffer. While storing, it tracks the bin with the largest power. Once the frame is complete, it stalls the producer and exposes the frame to a host through a registered read port until the host releases it.

---
 rtl/fft_frame_sink.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: receiving end of the FFT push/stall output stream.
// Collects one FRAME_LEN-point complex frame into a buffer and tracks the
// bin of maximum power while filling. After the last sample it stalls the
// producer and exposes the frame through a 1-cycle-latency read port until
// the host releases it.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_push/in_real/in_imag  producer sample; in_stall back to producer
//   rd_en/rd_addr         host read request (serviced only while holding)
//   rd_valid/rd_real/rd_imag registered read response
//   rd_release            host frees the buffer
//   frame_done            one-cycle pulse after the final accept of a frame
//   peak_bin/peak_pow     index and power of the strongest bin
//   frame_cnt             completed-frame counter, wraps 255->0
module fft_frame_sink #(
  parameter int FRAME_LEN = 16,
  parameter int DATA_W    = 16,
  localparam int AW       = $clog2(FRAME_LEN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_push,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     in_stall,
  input  logic                     rd_en,
  input  logic        [AW-1:0]     rd_addr,
  output logic                     rd_valid,
  output logic signed [DATA_W-1:0] rd_real,
  output logic signed [DATA_W-1:0] rd_imag,
  input  logic                     rd_release,
  output logic                     frame_done,
  output logic        [AW-1:0]     peak_bin,
  output logic      [2*DATA_W-1:0] peak_pow,
  output logic        [7:0]        frame_cnt
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e state_q, state_d;

  logic        [AW-1:0]     wr_cnt_q;
  logic        [AW-1:0]     peak_bin_q;
  logic      [2*DATA_W-1:0] peak_pow_q;
  logic        [7:0]        frame_cnt_q;
  logic                     frame_done_q;
  logic                     rd_valid_q;
  logic signed [DATA_W-1:0] rd_real_q, rd_imag_q;

  logic signed [DATA_W-1:0] buf_re [FRAME_LEN];
  logic signed [DATA_W-1:0] buf_im [FRAME_LEN];

  logic accept, last, first;
  assign accept = in_push && !in_stall;
  assign last   = (wr_cnt_q == AW'(FRAME_LEN - 1));
  assign first  = (wr_cnt_q == '0);

  // Power at 2*DATA_W bits: each square is non-negative and the sum peaks
  // at 2^(2*DATA_W-1), so the unsigned sum never overflows.
  logic signed [2*DATA_W-1:0] re_x, im_x, sq_re, sq_im;
  logic        [2*DATA_W-1:0] pow;
  assign re_x  = {{DATA_W{in_real[DATA_W-1]}}, in_real};
  assign im_x  = {{DATA_W{in_imag[DATA_W-1]}}, in_imag};
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;
  assign pow   = sq_re + sq_im;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (accept && last) state_d = HOLD;
      HOLD: if (rd_release)     state_d = FILL;
      default:                  state_d = FILL;
    endcase
  end

  // Outputs: stall is a pure decode of the state register, so there is no
  // combinational path from in_push.
  always_comb begin
    in_stall = (state_q == HOLD);
  end

  // Frame buffer; contents survive reset, the write pointer does not.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      buf_re[wr_cnt_q] <= in_real;
      buf_im[wr_cnt_q] <= in_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q     <= '0;
      peak_bin_q   <= '0;
      peak_pow_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_real_q    <= '0;
      rd_imag_q    <= '0;
    end else begin
      frame_done_q <= accept && last;
      rd_valid_q   <= 1'b0;
      if (accept) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        // Strict compare keeps the lowest index on ties.
        if (first || (pow > peak_pow_q)) begin
          peak_bin_q <= wr_cnt_q;
          peak_pow_q <= pow;
        end
        if (last) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      if (state_q == HOLD) begin
        rd_valid_q <= rd_en;
        if (rd_en) begin
          rd_real_q <= buf_re[rd_addr];
          rd_imag_q <= buf_im[rd_addr];
        end
        if (rd_release) begin
          peak_bin_q <= '0;
          peak_pow_q <= '0;
        end
      end
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_real    = rd_real_q;
  assign rd_imag    = rd_imag_q;
  assign frame_done = frame_done_q;
  assign peak_bin   = peak_bin_q;
  assign peak_pow   = peak_pow_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
